// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - parametrised universal shift register with frame counter
module universal_shift_register #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    if (WIDTH < 2) begin : g_width_check
        $error("universal_shift_register: WIDTH must be 2 or more");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             shifting;

    always_comb begin
        q_d          = q_q;
        cnt_d        = cnt_q;
        frame_done_d = frame_done_q;
        shifting     = 1'b0;
        if (en) begin
            frame_done_d = 1'b0;
            case (mode_e'(mode))
                MODE_LEFT: begin
                    q_d      = {q_q[WIDTH-2:0], serial_in};
                    shifting = 1'b1;
                end
                MODE_RIGHT: begin
                    q_d      = {serial_in, q_q[WIDTH-1:1]};
                    shifting = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = parallel_in;
                    cnt_d = '0;
                end
                default: ;
            endcase
            // Both shift directions advance the same frame count.
            if (shifting) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q          <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            q_q          <= q_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign q          = q_q;
    assign frame_done = frame_done_q;
    assign serial_out = (mode == MODE_RIGHT) ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - directed self-checking bench for universal_shift_register
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       serial_in;
    logic [3:0] parallel_in;
    logic [3:0] q;
    logic       serial_out;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;

    universal_shift_register #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .serial_in(serial_in),
        .parallel_in(parallel_in),
        .q(q),
        .serial_out(serial_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        mode = 2'b11;
        parallel_in = v;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'b11; parallel_in = 4'b1111; serial_in = 1'b1;
        step();
        step();
        n_cmp++;
        if (q !== 4'b0000) begin $display("FAIL reset_q: got %b want 0000", q); n_err++; end
        n_cmp++;
        if (frame_done !== 1'b0) begin $display("FAIL reset_fd: got %b want 0", frame_done); n_err++; end
        n_cmp++;
        if (serial_out !== 1'b0) begin $display("FAIL reset_so: got %b want 0", serial_out); n_err++; end
        rst = 1'b0;
    endtask

    task automatic test_shift_left();
        logic [3:0] bits  = 4'b1101;
        logic [3:0] exp_q [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            serial_in = bits[i];
            step();
            n_cmp++;
            if (q !== exp_q[i]) begin $display("FAIL left_q[%0d]: got %b want %b", i, q, exp_q[i]); n_err++; end
            n_cmp++;
            if (frame_done !== (i == 3)) begin $display("FAIL left_fd[%0d]: got %b want %b", i, frame_done, i == 3); n_err++; end
        end
        n_cmp++;
        if (serial_out !== 1'b1) begin $display("FAIL left_so: got %b want 1", serial_out); n_err++; end
        mode = 2'b00;
        step();
        n_cmp++;
        if (frame_done !== 1'b0 || q !== 4'b1011) begin
            $display("FAIL left_hold: got fd=%b q=%b want fd=0 q=1011", frame_done, q); n_err++;
        end
    endtask

    task automatic test_shift_right();
        logic [3:0] bits  = 4'b0001;
        logic [3:0] exp_q [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        load(4'b0000);
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            serial_in = bits[i];
            step();
            n_cmp++;
            if (q !== exp_q[i]) begin $display("FAIL right_q[%0d]: got %b want %b", i, q, exp_q[i]); n_err++; end
            n_cmp++;
            if (frame_done !== (i == 3)) begin $display("FAIL right_fd[%0d]: got %b want %b", i, frame_done, i == 3); n_err++; end
        end
        n_cmp++;
        if (serial_out !== 1'b1) begin $display("FAIL right_so: got %b want 1", serial_out); n_err++; end
    endtask

    task automatic test_load_mid_frame();
        logic [3:0] exp_q [4] = '{4'b0100, 4'b1000, 4'b0000, 4'b0000};
        load(4'b0000);
        mode = 2'b01; serial_in = 1'b0;
        step();
        step();
        load(4'b1010);
        n_cmp++;
        if (q !== 4'b1010 || frame_done !== 1'b0) begin
            $display("FAIL load_mid: got q=%b fd=%b want q=1010 fd=0", q, frame_done); n_err++;
        end
        mode = 2'b01; serial_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (q !== exp_q[i]) begin $display("FAIL load_q[%0d]: got %b want %b", i, q, exp_q[i]); n_err++; end
            n_cmp++;
            if (frame_done !== (i == 3)) begin $display("FAIL load_fd[%0d]: got %b want %b", i, frame_done, i == 3); n_err++; end
        end
    endtask

    task automatic test_enable_hold();
        load(4'b0000);
        mode = 2'b01; serial_in = 1'b1;
        step();
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (q !== 4'b0011 || frame_done !== 1'b0) begin
                $display("FAIL stall[%0d]: got q=%b fd=%b want q=0011 fd=0", i, q, frame_done); n_err++;
            end
        end
        en = 1'b1; mode = 2'b00; serial_in = 1'bx;
        step();
        n_cmp++;
        if (q !== 4'b0011 || frame_done !== 1'b0) begin
            $display("FAIL hold_edge: got q=%b fd=%b want q=0011 fd=0", q, frame_done); n_err++;
        end
        mode = 2'b01; serial_in = 1'b1;
        step();
        n_cmp++;
        if (q !== 4'b0111 || frame_done !== 1'b0) begin
            $display("FAIL en_shift3: got q=%b fd=%b want q=0111 fd=0", q, frame_done); n_err++;
        end
        step();
        n_cmp++;
        if (q !== 4'b1111 || frame_done !== 1'b1) begin
            $display("FAIL en_shift4: got q=%b fd=%b want q=1111 fd=1", q, frame_done); n_err++;
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (q !== 4'b1111 || frame_done !== 1'b1) begin
                $display("FAIL fd_stretch[%0d]: got q=%b fd=%b want q=1111 fd=1", i, q, frame_done); n_err++;
            end
        end
        en = 1'b1; mode = 2'b00;
        step();
        n_cmp++;
        if (frame_done !== 1'b0) begin $display("FAIL fd_release: got %b want 0", frame_done); n_err++; end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits = 8'b0100_1011;
        logic [3:0] exp_q [8] = '{4'b0001, 4'b0011, 4'b0110, 4'b1101,
                                  4'b1010, 4'b0100, 4'b1001, 4'b0010};
        load(4'b0000);
        mode = 2'b01; serial_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (q !== 4'b0000 || frame_done !== 1'b0) begin
            $display("FAIL rst_mid: got q=%b fd=%b want q=0000 fd=0", q, frame_done); n_err++;
        end
        for (int i = 0; i < 8; i++) begin
            serial_in = bits[i];
            step();
            n_cmp++;
            if (q !== exp_q[i]) begin $display("FAIL b2b_q[%0d]: got %b want %b", i, q, exp_q[i]); n_err++; end
            n_cmp++;
            if (frame_done !== (i == 3 || i == 7)) begin
                $display("FAIL b2b_fd[%0d]: got %b want %b", i, frame_done, (i == 3 || i == 7)); n_err++;
            end
        end
    endtask

    task automatic test_mixed_direction();
        logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [3:0] bits = 4'b0011;
        logic [3:0] exp_q [4] = '{4'b0101, 4'b1010, 4'b0100, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            mode = modes[i]; serial_in = bits[i];
            step();
            n_cmp++;
            if (q !== exp_q[i]) begin $display("FAIL mix_q[%0d]: got %b want %b", i, q, exp_q[i]); n_err++; end
            n_cmp++;
            if (frame_done !== (i == 3)) begin $display("FAIL mix_fd[%0d]: got %b want %b", i, frame_done, i == 3); n_err++; end
        end
        n_cmp++;
        if (serial_out !== 1'b0) begin $display("FAIL mix_so: got %b want 0", serial_out); n_err++; end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'b00; serial_in = 1'b0; parallel_in = 4'b0000;
        test_reset();
        test_shift_left();
        test_shift_right();
        test_load_mid_frame();
        test_enable_hold();
        test_back_to_back();
        test_mixed_direction();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
